// File: rtl/edge_bram_arbiter.sv
// Edge-map BRAM owner: raster writer fills a frame, then the Hough reader
// drains it exclusively until it signals done.
module edge_bram_arbiter #(
    parameter int WIDTH        = 1280,
    parameter int HEIGHT       = 720,
    parameter int IMAGE_SIZE   = WIDTH * HEIGHT,
    parameter int ADDR_W       = $clog2(IMAGE_SIZE),
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    input  logic              rd_frame_done,
    output logic              frame_ready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wdata,
    input  logic [7:0]        bram_rdata,
    output logic [ADDR_W:0]   wr_count,
    output logic [15:0]       frame_count,
    output logic              seq_err,
    output logic              addr_err
);

    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic [ADDR_W:0] IMG    = (ADDR_W+1)'(IMAGE_SIZE);
    localparam logic [ADDR_W:0] IMG_M1 = (ADDR_W+1)'(IMAGE_SIZE - 1);
    localparam logic [3:0]      SLIM   = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_wr_count;
    logic [15:0]       r_frame_count;
    logic [3:0]        r_starve;
    logic              r_rd_valid;
    logic              r_rd_oor;
    logic              r_frame_ready;
    logic              r_seq_err;
    logic              r_addr_err;

    logic              w_in_range;
    logic              w_elig;
    logic              w_rd_gnt;
    logic              w_wr_gnt;
    logic              w_last_wr;
    logic              w_rearm;
    logic              w_rd_bram;

    assign w_in_range = {1'b0, rd_addr} < IMG;
    assign w_last_wr  = w_wr_gnt && (r_wr_count == IMG_M1);
    assign w_rearm    = (r_state == DRAIN) && rd_frame_done;
    assign w_rd_bram  = w_rd_gnt && w_in_range;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= FILL;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FILL:  if (w_last_wr) w_next = DRAIN;
            DRAIN: if (rd_frame_done) w_next = FILL;
        endcase
    end

    // FILL reads only behind the watermark; starvation lets one read through
    always_comb begin
        w_elig   = 1'b0;
        w_rd_gnt = 1'b0;
        w_wr_gnt = 1'b0;
        unique case (r_state)
            FILL: begin
                w_elig   = rd_req && ({1'b0, rd_addr} < r_wr_count);
                w_rd_gnt = w_elig && (!wr_req || r_starve == SLIM);
                w_wr_gnt = wr_req && !w_rd_gnt;
            end
            DRAIN: begin
                w_elig   = rd_req;
                w_rd_gnt = rd_req;
            end
        endcase
    end

    always_comb begin
        bram_en    = w_wr_gnt || w_rd_bram;
        bram_we    = w_wr_gnt;
        bram_addr  = '0;
        bram_wdata = '0;
        if (w_wr_gnt) begin
            bram_addr  = wr_addr;
            bram_wdata = wr_data;
        end else if (w_rd_bram) begin
            bram_addr  = rd_addr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_count    <= '0;
            r_frame_count <= '0;
            r_starve      <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_oor      <= 1'b0;
            r_frame_ready <= 1'b0;
            r_seq_err     <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            r_rd_valid    <= w_rd_gnt;
            r_rd_oor      <= w_rd_gnt && !w_in_range;
            r_frame_ready <= w_last_wr;
            if (w_rearm) begin
                r_wr_count    <= '0;
                r_frame_count <= r_frame_count + 16'd1;
            end else if (w_wr_gnt) begin
                r_wr_count    <= r_wr_count + 1'b1;
            end
            if (w_rearm || w_rd_gnt || !w_elig)
                r_starve <= '0;
            else if (r_starve != SLIM)
                r_starve <= r_starve + 4'd1;
            if (w_wr_gnt && ({1'b0, wr_addr} != r_wr_count))
                r_seq_err <= 1'b1;
            if (w_rd_gnt && !w_in_range)
                r_addr_err <= 1'b1;
        end
    end

    assign wr_gnt      = w_wr_gnt;
    assign rd_gnt      = w_rd_gnt;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = (r_rd_valid && !r_rd_oor) ? bram_rdata : 8'd0;
    assign frame_ready = r_frame_ready;
    assign wr_count    = r_wr_count;
    assign frame_count = r_frame_count;
    assign seq_err     = r_seq_err;
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_edge_bram_arbiter.sv
// Directed bench for edge_bram_arbiter with a 4x3 frame and a BRAM model;
// read returns are checked by a scoreboard monitor.
module tb_edge_bram_arbiter;

    localparam int AW = 4;

    logic          clock;
    logic          reset;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_frame_done;
    logic          frame_ready;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_wdata;
    logic [7:0]    bram_rdata;
    logic [AW:0]   wr_count;
    logic [15:0]   frame_count;
    logic          seq_err;
    logic          addr_err;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[16];

    edge_bram_arbiter #(
        .WIDTH(4), .HEIGHT(3), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_frame_done(rd_frame_done), .frame_ready(frame_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .wr_count(wr_count), .frame_count(frame_count),
        .seq_err(seq_err), .addr_err(addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port BRAM with one-cycle read latency
    always @(posedge clock) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
        if (bram_en && !bram_we) bram_rdata <= mem[bram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got %0h expected none",
                         rd_data);
            end else begin
                chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drv(input logic wq, input logic [AW-1:0] wa,
                       input logic [7:0] wd, input logic rq,
                       input logic [AW-1:0] ra, input logic dn);
        wr_req = wq; wr_addr = wa; wr_data = wd;
        rd_req = rq; rd_addr = ra; rd_frame_done = dn;
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bram_rdata = 8'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_errs", {seq_err, addr_err}, 0);
        chk("rst_bram_en", bram_en, 0);
        nxt();
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drv(1, AW'(i), 8'hA0 + 8'(i), 0, 0, 0);
            @(negedge clock);
            chk("fill_wr_gnt", wr_gnt, 1);
            chk("fill_bram_addr", bram_addr, i);
            chk("fill_no_ready", frame_ready, 0);
            nxt();
        end

        drv(1, 0, 8'hEE, 0, 0, 0);
        @(negedge clock);
        chk("frame_ready_pulse", frame_ready, 1);
        chk("full_wr_count", wr_count, 12);
        chk("drain_wr_gnt", wr_gnt, 0);
        chk("drain_bram_en", bram_en, 0);
        nxt();

        drv(0, 0, 0, 1, 4'd12, 0);
        exp_q.push_back(8'h00);
        @(negedge clock);
        chk("oor_rd_gnt", rd_gnt, 1);
        chk("oor_bram_en", bram_en, 0);
        chk("frame_ready_once", frame_ready, 0);
        nxt();

        drv(0, 0, 0, 1, 4'd3, 0);
        exp_q.push_back(8'hA3);
        @(negedge clock);
        chk("addr_err_set", addr_err, 1);
        chk("drain_rd_gnt", rd_gnt, 1);
        chk("drain_bram_addr", bram_addr, 3);
        chk("drain_bram_we", bram_we, 0);
        nxt();

        drv(0, 0, 0, 1, 4'd5, 1);
        exp_q.push_back(8'hA5);
        @(negedge clock);
        chk("done_rd_gnt", rd_gnt, 1);
        nxt();

        drv(1, 4'd2, 8'h52, 0, 0, 0);
        @(negedge clock);
        chk("rearm_wr_count", wr_count, 0);
        chk("rearm_frame_count", frame_count, 1);
        chk("bad_seq_wr_gnt", wr_gnt, 1);
        chk("bad_seq_bram", {bram_we, bram_addr, bram_wdata},
            {1'b1, 4'd2, 8'h52});
        nxt();

        for (int a = 1; a < 5; a++) begin
            drv(1, AW'(a), 8'h60 + 8'(a), 0, 0, 0);
            nxt();
        end
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("seq_err_set", seq_err, 1);
        chk("fill2_wr_count", wr_count, 5);
        nxt();

        for (int k = 0; k < 2; k++) begin
            drv(0, 0, 0, 1, 4'd7, 0);
            @(negedge clock);
            chk("ahead_rd_gnt", rd_gnt, 0);
            chk("ahead_starve", dut.r_starve, 0);
            nxt();
        end

        exp_q.push_back(8'h63);
        for (int k = 0; k < 4; k++) begin
            drv(1, AW'(5 + k), 8'h75 + 8'(k), 1, 4'd3, 0);
            @(negedge clock);
            chk("starve_rd_gnt", rd_gnt, 0);
            chk("starve_wr_gnt", wr_gnt, 1);
            nxt();
        end
        drv(1, 4'd9, 8'h79, 1, 4'd3, 0);
        @(negedge clock);
        chk("starved_rd_gnt", rd_gnt, 1);
        chk("starved_wr_gnt", wr_gnt, 0);
        chk("starved_bram", {bram_en, bram_we, bram_addr},
            {1'b1, 1'b0, 4'd3});
        nxt();

        drv(0, 0, 0, 1, 4'd7, 0);
        exp_q.push_back(8'h77);
        @(negedge clock);
        chk("behind_rd_gnt", rd_gnt, 1);
        chk("behind_wr_count", wr_count, 9);
        chk("behind_starve", dut.r_starve, 0);
        nxt();

        drv(0, 0, 0, 1, 4'd4, 0);
        nxt();
        chk("pre_rst_rd_valid", rd_valid, 1);
        drv(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("async_rd_valid", rd_valid, 0);
        chk("async_wr_count", wr_count, 0);
        chk("async_frame_count", frame_count, 0);
        chk("async_errs", {seq_err, addr_err}, 0);
        nxt();
        reset = 1'b1;

        drv(1, 0, 8'h11, 0, 0, 0);
        @(negedge clock);
        chk("post_rst_wr_gnt", wr_gnt, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("post_rst_wr_count", wr_count, 1);
        chk("post_rst_seq_err", seq_err, 0);
        nxt();
        nxt();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
